// File: rtl/acq_sequencer.sv
// acq_sequencer: programmable acquisition sequencer for NCH ADC channels.
// Runs epochs of `period` cycles. At the programmed times within each epoch
// it pulses the AGC DAC load, issues per-channel ADC control-word loads and
// raises the per-channel ADC enables. Runs one-shot or periodic.
//
// Optional feature macro: ACQSEQ_MBUSY_WAIT_EN
//   defined   : a control-word load for channel i is held pending while the
//               registered adc_mbusy[i] is high, and it goes out one cycle
//               after mbusy falls. Loads still pending at epoch end are dropped.
//   undefined : adc_mbusy is ignored and loads fire on the event cycle.
//
// Ports:
//   clk, rst       system clock, synchronous active-high reset
//   start, stop    arm/run request (sampled in IDLE), abort
//   periodic       1 = restart the epoch at its end, 0 = one-shot
//   ch_mask        channels taking part in ldctrl/enable
//   period         epoch length in cycles
//   t_agc, t_ldctrl, t_enable  event times within the epoch
//   ctrlword_in    ADC control word, latched on start
//   agc_in         AGC DAC code, latched on start
//   adc_mbusy      per-channel adc_if busy
//   adc_ldctrl     one-cycle control-word load strobe per channel
//   adc_enable     ADC conversion enable level per channel
//   adc_ctrlword   latched control word
//   agc_load       one-cycle AGC write strobe
//   agc_data       latched AGC code
//   busy           high while running
//   done           one-cycle pulse at the end of a one-shot epoch
//   cfg_err        one-cycle pulse when a start is rejected
//   epoch_cnt      completed epochs, wraps
module acq_sequencer #(
  parameter int unsigned NCH     = 2,
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned CTRL_W  = 10,
  parameter int unsigned AGC_W   = 12,
  parameter int unsigned EPOCH_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               periodic,
  input  logic [NCH-1:0]     ch_mask,
  input  logic [CNT_W-1:0]   period,
  input  logic [CNT_W-1:0]   t_agc,
  input  logic [CNT_W-1:0]   t_ldctrl,
  input  logic [CNT_W-1:0]   t_enable,
  input  logic [CTRL_W-1:0]  ctrlword_in,
  input  logic [AGC_W-1:0]   agc_in,
  input  logic [NCH-1:0]     adc_mbusy,
  output logic [NCH-1:0]     adc_ldctrl,
  output logic [NCH-1:0]     adc_enable,
  output logic [CTRL_W-1:0]  adc_ctrlword,
  output logic               agc_load,
  output logic [AGC_W-1:0]   agc_data,
  output logic               busy,
  output logic               done,
  output logic               cfg_err,
  output logic [EPOCH_W-1:0] epoch_cnt
);

  localparam logic [CTRL_W-1:0] CTRL_RST = CTRL_W'(10'h024);
  localparam logic [AGC_W-1:0]  AGC_RST  = AGC_W'(12'h555);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t             state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;

  // Configuration captured on an accepted start
  logic [NCH-1:0]     mask_q, mask_d;
  logic               periodic_q, periodic_d;
  logic [CNT_W-1:0]   period_q, period_d;
  logic [CNT_W-1:0]   t_agc_q, t_agc_d;
  logic [CNT_W-1:0]   t_ldctrl_q, t_ldctrl_d;
  logic [CNT_W-1:0]   t_enable_q, t_enable_d;

  // Next values of the registered outputs
  logic [NCH-1:0]     ldctrl_d, enable_d;
  logic [CTRL_W-1:0]  ctrlword_d;
  logic               agc_load_d;
  logic [AGC_W-1:0]   agc_data_d;
  logic               busy_d, done_d, cfg_err_d;
  logic [EPOCH_W-1:0] epoch_d;

  logic               cfg_ok;
  logic [NCH-1:0]     ld_ev;

`ifdef ACQSEQ_MBUSY_WAIT_EN
  logic [NCH-1:0]     pending, pending_d;
  logic [NCH-1:0]     mbusy_q;
  logic [NCH-1:0]     ld_req;
`else
  logic               unused_mbusy;
  assign unused_mbusy = ^adc_mbusy;
`endif

  // Start is accepted only if every event time lies inside a non-empty epoch
  assign cfg_ok = (period != '0) && (t_agc < period) &&
                  (t_ldctrl < period) && (t_enable < period);

  // Next-state and output logic
  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    mask_d     = mask_q;
    periodic_d = periodic_q;
    period_d   = period_q;
    t_agc_d    = t_agc_q;
    t_ldctrl_d = t_ldctrl_q;
    t_enable_d = t_enable_q;
    ldctrl_d   = '0;
    enable_d   = adc_enable;
    ctrlword_d = adc_ctrlword;
    agc_load_d = 1'b0;
    agc_data_d = agc_data;
    done_d     = 1'b0;
    cfg_err_d  = 1'b0;
    epoch_d    = epoch_cnt;
    ld_ev      = '0;
`ifdef ACQSEQ_MBUSY_WAIT_EN
    pending_d  = pending;
    ld_req     = '0;
`endif

    case (state)
      S_IDLE: begin
        if (start && !stop) begin
          if (cfg_ok) begin
            mask_d     = ch_mask;
            periodic_d = periodic;
            period_d   = period;
            t_agc_d    = t_agc;
            t_ldctrl_d = t_ldctrl;
            t_enable_d = t_enable;
            ctrlword_d = ctrlword_in;
            agc_data_d = agc_in;
            cnt_d      = '0;
            state_d    = S_RUN;
          end else begin
            cfg_err_d  = 1'b1;
          end
        end
      end

      S_RUN: begin
        if (stop) begin
          enable_d = '0;
`ifdef ACQSEQ_MBUSY_WAIT_EN
          pending_d = '0;
`endif
          state_d  = S_IDLE;
        end else begin
          cnt_d = cnt + CNT_W'(1);

          if (cnt == t_agc_q)    agc_load_d = 1'b1;
          if (cnt == t_enable_q) enable_d   = mask_q;
          if (cnt == t_ldctrl_q) ld_ev      = mask_q;

`ifdef ACQSEQ_MBUSY_WAIT_EN
          // A load goes out only while the channel's registered busy is low
          ld_req    = pending | ld_ev;
          ldctrl_d  = ld_req & ~mbusy_q;
          pending_d = ld_req & mbusy_q;
`else
          ldctrl_d  = ld_ev;
`endif

          // Epoch end overrides the enable event and drops undelivered loads
          if (cnt == period_q - CNT_W'(1)) begin
            enable_d = '0;
`ifdef ACQSEQ_MBUSY_WAIT_EN
            pending_d = '0;
`endif
            epoch_d  = epoch_cnt + EPOCH_W'(1);
            if (periodic_q) begin
              cnt_d   = '0;
            end else begin
              done_d  = 1'b1;
              state_d = S_IDLE;
            end
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_RUN);
  end

  // State, configuration and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      cnt          <= '0;
      mask_q       <= '0;
      periodic_q   <= 1'b0;
      period_q     <= '0;
      t_agc_q      <= '0;
      t_ldctrl_q   <= '0;
      t_enable_q   <= '0;
      adc_ldctrl   <= '0;
      adc_enable   <= '0;
      adc_ctrlword <= CTRL_RST;
      agc_load     <= 1'b0;
      agc_data     <= AGC_RST;
      busy         <= 1'b0;
      done         <= 1'b0;
      cfg_err      <= 1'b0;
      epoch_cnt    <= '0;
`ifdef ACQSEQ_MBUSY_WAIT_EN
      pending      <= '0;
      mbusy_q      <= '0;
`endif
    end else begin
      state        <= state_d;
      cnt          <= cnt_d;
      mask_q       <= mask_d;
      periodic_q   <= periodic_d;
      period_q     <= period_d;
      t_agc_q      <= t_agc_d;
      t_ldctrl_q   <= t_ldctrl_d;
      t_enable_q   <= t_enable_d;
      adc_ldctrl   <= ldctrl_d;
      adc_enable   <= enable_d;
      adc_ctrlword <= ctrlword_d;
      agc_load     <= agc_load_d;
      agc_data     <= agc_data_d;
      busy         <= busy_d;
      done         <= done_d;
      cfg_err      <= cfg_err_d;
      epoch_cnt    <= epoch_d;
`ifdef ACQSEQ_MBUSY_WAIT_EN
      pending      <= pending_d;
      mbusy_q      <= adc_mbusy;
`endif
    end
  end

endmodule

// File: tb/tb_acq_sequencer.sv
// Testbench for acq_sequencer: directed runs, expected strobe/level events
// queued per run and matched in order against events seen on the outputs.
module tb_acq_sequencer;

  localparam int unsigned NCH = 2;
  localparam int K_AGC = 0, K_LD = 1, K_EN = 2, K_DONE = 3, K_CFG = 4;

  typedef struct {
    int cyc;
    int kind;
    int val;
  } ev_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic              periodic = 1'b0;
  logic [NCH-1:0]    ch_mask = '0;
  logic [31:0]       period = '0;
  logic [31:0]       t_agc = '0;
  logic [31:0]       t_ldctrl = '0;
  logic [31:0]       t_enable = '0;
  logic [9:0]        ctrlword_in = '0;
  logic [11:0]       agc_in = '0;
  logic [NCH-1:0]    adc_mbusy = '0;
  logic [NCH-1:0]    adc_ldctrl;
  logic [NCH-1:0]    adc_enable;
  logic [9:0]        adc_ctrlword;
  logic              agc_load;
  logic [11:0]       agc_data;
  logic              busy;
  logic              done;
  logic              cfg_err;
  logic [15:0]       epoch_cnt;

  acq_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .periodic(periodic),
    .ch_mask(ch_mask), .period(period), .t_agc(t_agc), .t_ldctrl(t_ldctrl),
    .t_enable(t_enable), .ctrlword_in(ctrlword_in), .agc_in(agc_in),
    .adc_mbusy(adc_mbusy), .adc_ldctrl(adc_ldctrl), .adc_enable(adc_enable),
    .adc_ctrlword(adc_ctrlword), .agc_load(agc_load), .agc_data(agc_data),
    .busy(busy), .done(done), .cfg_err(cfg_err), .epoch_cnt(epoch_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;
  ev_t exp_q[$];
  ev_t obs_q[$];
  logic mon_en = 1'b0;
  logic [NCH-1:0] en_prev = '0;

  // Output monitor: one record per strobe, and per change of the enable level
  always @(negedge clk) begin
    if (mon_en) begin
      if (agc_load)            obs_q.push_back('{cyc, K_AGC, 0});
      if (adc_ldctrl != '0)    obs_q.push_back('{cyc, K_LD, int'(adc_ldctrl)});
      if (adc_enable != en_prev) obs_q.push_back('{cyc, K_EN, int'(adc_enable)});
      if (done)                obs_q.push_back('{cyc, K_DONE, 0});
      if (cfg_err)             obs_q.push_back('{cyc, K_CFG, 0});
      en_prev = adc_enable;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [63:0] pack(input ev_t e);
    return {32'(e.cyc), 16'(e.kind), 16'(e.val)};
  endfunction

  task automatic expect_ev(input int c, input int k, input int v);
    exp_q.push_back('{c, k, v});
  endtask

  // Match queued expectations in order against observed events
  task automatic drain(input string tag);
    ev_t e, o;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_q.size() == 0) begin
        check({tag, "_missing"}, 64'hFFFF_FFFF_FFFF_FFFF, pack(e));
      end else begin
        o = obs_q.pop_front();
        check(tag, pack(o), pack(e));
      end
    end
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      check({tag, "_extra"}, pack(o), 64'hDEAD_0000_DEAD_0000);
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Called at a negedge; the following posedge is E0. Returns at E0's negedge.
  task automatic start_run(input int p, input int ta, input int tl, input int te,
                           input logic [NCH-1:0] m, input logic per,
                           input logic [9:0] cw, input logic [11:0] ag,
                           output int e0);
    period = 32'(p); t_agc = 32'(ta); t_ldctrl = 32'(tl); t_enable = 32'(te);
    ch_mask = m; periodic = per; ctrlword_in = cw; agc_in = ag;
    start = 1'b1;
    e0 = cyc + 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    int e0;
    int ep0;

    // Reset and idle
    repeat (3) @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;
    check("rst_ctrlword", 64'(adc_ctrlword), 64'h024);
    check("rst_agc_data", 64'(agc_data), 64'h555);
    check("rst_epoch", 64'(epoch_cnt), 64'd0);
    repeat (10) @(negedge clk);
    check("idle_outputs", 64'({adc_ldctrl, adc_enable, agc_load, busy, done, cfg_err}), 64'd0);
    check("idle_ctrlword", 64'(adc_ctrlword), 64'h024);
    check("idle_agc_data", 64'(agc_data), 64'h555);
    drain("idle_ev");

    // One-shot epoch, all channels
    start_run(20, 2, 5, 8, 2'b11, 1'b0, 10'h2A5, 12'hABC, e0);
    check("os_busy", 64'(busy), 64'd1);
    check("os_ctrlword", 64'(adc_ctrlword), 64'h2A5);
    check("os_agc_data", 64'(agc_data), 64'hABC);
    expect_ev(e0 + 3, K_AGC, 0);
    expect_ev(e0 + 6, K_LD, 3);
    expect_ev(e0 + 9, K_EN, 3);
    expect_ev(e0 + 20, K_EN, 0);
    expect_ev(e0 + 20, K_DONE, 0);
    wait_until(e0 + 25);
    drain("os_ev");
    check("os_epoch", 64'(epoch_cnt), 64'd1);
    check("os_busy_end", 64'(busy), 64'd0);

    // Periodic run, stop sampled at E45: two full epochs then an abort
    start_run(20, 2, 5, 8, 2'b11, 1'b1, 10'h2A5, 12'hABC, e0);
    for (int k = 0; k < 2; k++) begin
      expect_ev(e0 + 20*k + 3, K_AGC, 0);
      expect_ev(e0 + 20*k + 6, K_LD, 3);
      expect_ev(e0 + 20*k + 9, K_EN, 3);
      expect_ev(e0 + 20*k + 20, K_EN, 0);
    end
    expect_ev(e0 + 43, K_AGC, 0);
    wait_until(e0 + 44);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("per_busy_stop", 64'(busy), 64'd0);
    wait_until(e0 + 60);
    drain("per_ev");
    check("per_epoch", 64'(epoch_cnt), 64'd3);
    check("per_enable", 64'(adc_enable), 64'd0);

    // Stop while enables are high: enable drops, no done, count unchanged
    ep0 = int'(epoch_cnt);
    start_run(20, 2, 5, 8, 2'b01, 1'b0, 10'h111, 12'h222, e0);
    expect_ev(e0 + 3, K_AGC, 0);
    expect_ev(e0 + 6, K_LD, 1);
    expect_ev(e0 + 9, K_EN, 1);
    expect_ev(e0 + 13, K_EN, 0);
    wait_until(e0 + 12);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    wait_until(e0 + 30);
    drain("stop_ev");
    check("stop_epoch", 64'(epoch_cnt), 64'(ep0));
    check("stop_busy", 64'(busy), 64'd0);

    // Rejected start: t_enable == period
    start_run(10, 1, 1, 10, 2'b11, 1'b0, 10'h333, 12'h123, e0);
    check("cfg_busy", 64'(busy), 64'd0);
    expect_ev(e0, K_CFG, 0);
    wait_until(e0 + 5);
    drain("cfg_ev");
    check("cfg_agc_data", 64'(agc_data), 64'h222);
    check("cfg_ctrlword", 64'(adc_ctrlword), 64'h111);

    // Rejected start: period == 0
    start_run(0, 0, 0, 0, 2'b11, 1'b0, 10'h333, 12'h123, e0);
    expect_ev(e0, K_CFG, 0);
    wait_until(e0 + 5);
    drain("cfg0_ev");

    // All events on the last cycle: enable never rises
    ep0 = int'(epoch_cnt);
    start_run(20, 19, 19, 19, 2'b10, 1'b0, 10'h0F0, 12'h0F0, e0);
    expect_ev(e0 + 20, K_AGC, 0);
    expect_ev(e0 + 20, K_LD, 2);
    expect_ev(e0 + 20, K_DONE, 0);
    wait_until(e0 + 25);
    drain("last_ev");
    check("last_epoch", 64'(epoch_cnt), 64'(ep0 + 1));

    // Reset in the middle of a run
    start_run(20, 2, 5, 8, 2'b11, 1'b0, 10'h3FF, 12'hFFF, e0);
    expect_ev(e0 + 3, K_AGC, 0);
    expect_ev(e0 + 6, K_LD, 3);
    expect_ev(e0 + 9, K_EN, 3);
    expect_ev(e0 + 11, K_EN, 0);
    wait_until(e0 + 10);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mrst_ctrlword", 64'(adc_ctrlword), 64'h024);
    check("mrst_agc_data", 64'(agc_data), 64'h555);
    check("mrst_epoch", 64'(epoch_cnt), 64'd0);
    check("mrst_busy", 64'(busy), 64'd0);
    wait_until(e0 + 30);
    drain("mrst_ev");

`ifdef ACQSEQ_MBUSY_WAIT_EN
    // mbusy[0] high over E4..E9 delays the load to E11
    start_run(20, 2, 5, 8, 2'b01, 1'b0, 10'h024, 12'h555, e0);
    expect_ev(e0 + 3, K_AGC, 0);
    expect_ev(e0 + 9, K_EN, 1);
    expect_ev(e0 + 11, K_LD, 1);
    expect_ev(e0 + 20, K_EN, 0);
    expect_ev(e0 + 20, K_DONE, 0);
    wait_until(e0 + 3);
    adc_mbusy = 2'b01;
    wait_until(e0 + 9);
    adc_mbusy = 2'b00;
    wait_until(e0 + 25);
    drain("mb_ev");

    // mbusy held through epoch end: load dropped, nothing after release
    start_run(20, 2, 5, 8, 2'b01, 1'b0, 10'h024, 12'h555, e0);
    expect_ev(e0 + 3, K_AGC, 0);
    expect_ev(e0 + 9, K_EN, 1);
    expect_ev(e0 + 20, K_EN, 0);
    expect_ev(e0 + 20, K_DONE, 0);
    wait_until(e0 + 3);
    adc_mbusy = 2'b01;
    wait_until(e0 + 25);
    adc_mbusy = 2'b00;
    wait_until(e0 + 35);
    drain("mbhold_ev");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/acq_sequencer.md
# acq_sequencer

Programmable acquisition sequencer. It replaces the fixed-count free-running counter that currently drives ADC control-word loads, ADC enables and the AGC DAC load in the top level. It generalises to NCH ADC channels with a per-channel mask, runtime-programmable event times, and one-shot or periodic mode. It sits in the clk domain between the host/command logic and the adc_if / spiMasterWrite instances.

## Interface
- NCH, 2, number of ADC channels driven
- CNT_W, 32, width of epoch counter and all time inputs
- CTRL_W, 10, ADC control word width
- AGC_W, 12, AGC DAC word width
- EPOCH_W, 16, completed-epoch counter width
- clk  in  1  system clock (PLL GLA); one clock domain
- rst  in  1  synchronous, active-high reset
- start  in  1  request to arm and run; sampled in IDLE only
- stop  in  1  abort; returns to IDLE
- periodic  in  1  1 = restart epoch at end, 0 = one-shot
- ch_mask  in  NCH  channels participating in ldctrl/enable
- period  in  CNT_W  epoch length in cycles
- t_agc, t_ldctrl, t_enable  in  CNT_W  event times within epoch
- ctrlword_in  in  CTRL_W  ADC control word
- agc_in  in  AGC_W  AGC DAC code
- adc_mbusy  in  NCH  per-channel adc_if busy
- adc_ldctrl  out  NCH  one-cycle control-word load strobe
- adc_enable  out  NCH  ADC conversion enable level
- adc_ctrlword  out  CTRL_W  latched control word
- agc_load  out  1  one-cycle AGC write strobe
- agc_data  out  AGC_W  latched AGC code
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse at end of one-shot epoch
- cfg_err  out  1  one-cycle pulse on rejected start
- epoch_cnt  out  EPOCH_W  completed epochs, wraps

## Operation
- Reset values:
  - adc_ldctrl, adc_enable, agc_load, busy, done, cfg_err, epoch_cnt = 0
  - adc_ctrlword = 10'b0000100100
  - agc_data = 12'h555
  - state IDLE, cnt = 0, pending = 0
- IDLE, start=1, stop=0:
  - Config is valid when period != 0 and t_agc, t_ldctrl, t_enable are all < period.
  - Valid: latch ch_mask, periodic, period, t_*, ctrlword_in -> adc_ctrlword, agc_in -> agc_data; cnt <= 0; go to RUN.
  - Invalid: pulse cfg_err, stay in IDLE, no latching.
- IDLE, start and stop both high: no action.
- RUN: cnt increments every cycle. On the cycle where cnt equals a given time:
  - t_agc: agc_load pulse.
  - t_ldctrl: set pending[i] for each masked channel.
  - t_enable: adc_enable <= ch_mask.
- Pending load: pending[i] issues an adc_ldctrl[i] pulse and clears itself (see Configuration for the mbusy gating).
- Epoch end (cnt == period-1):
  - adc_enable <= 0; undelivered pending bits cleared; epoch_cnt++.
  - periodic=1: cnt <= 0, stay in RUN.
  - periodic=0: pulse done, go to IDLE.
- Events at equal times fire in the same cycle. t_enable == period-1: the epoch-end clear wins, so adc_enable stays 0.
- stop in RUN: the next edge clears adc_enable and pending, goes to IDLE, no done pulse, epoch_cnt unchanged.
- start in RUN: ignored. Inputs changed in RUN: no effect until the next start.
- rst mid-RUN: all outputs return to their reset values on the next edge.

## Timing
- Start sampled at edge E0: busy high after E0.
- Event at time T: its output is registered at E(T+1), i.e. visible for exactly one cycle, T+1 cycles after E0 (enable: level from then on).
- Epoch end for period P: enable low, done/epoch_cnt update after E(P). In periodic mode the next epoch's event T fires at E(P+T+1).
- All outputs are registered; no combinational input-to-output paths.

## Configuration
- ACQSEQ_MBUSY_WAIT_EN
  - Defined: pending[i] issues ldctrl only in a cycle where adc_mbusy[i]=0, so it is deferred while busy, and the pulse goes out one cycle after mbusy falls.
  - Undefined: adc_mbusy is ignored; ldctrl fires at the t_ldctrl event cycle unconditionally, and pending is a single-cycle stage.

## Test plan
- Reset, then idle 10 cycles -> all strobes 0, adc_ctrlword=0x024, agc_data=0x555, busy=0.
- NCH=2, period=20, t_agc=2, t_ldctrl=5, t_enable=8, mask=2'b11, one-shot, start at E0 -> agc_load at E3, ldctrl=2'b11 at E6, enable=2'b11 E9..E20, low at E20, done at E20, epoch_cnt=1.
- Same config, periodic=1, stop at E45 -> 2 epochs counted, enable low after E46, no done, busy=0.
- Start with period=10, t_enable=10 -> cfg_err one cycle, busy stays 0, agc_data unchanged.
- With ACQSEQ_MBUSY_WAIT_EN, mask=2'b01, adc_mbusy[0] high over E4..E9 -> adc_ldctrl[0] at E11 only. A second run with mbusy held high through the epoch end gives no ldctrl, and pending is cleared at epoch end.
- t_agc=t_ldctrl=t_enable=19, period=20 -> agc_load and ldctrl both at E20, adc_enable never rises.
